pps_rx: RTL and testbench
=========================

// Module: pps_rx
//
// PURPOSE
//  Receiver/monitor for an external one-pulse-per-second (PPS) input; the
//  counterpart to our integer-divide PPS generator. Synchronises the async
//  PPS line, measures clocks between rising edges, reports period and error
//  against the nominal clock rate, declares lock after consecutive in-tolerance
//  seconds and flags a missing pulse. Sits between a board PPS pin and the
//  timing/status logic; o_led gives a visible heartbeat.
//
// PARAMETERS
//  CLOCK_RATE_HZ  50_000_000  nominal i_clk cycles per PPS period
//  TOLERANCE      1_000       max |period - CLOCK_RATE_HZ| counted as good
//  LOCK_COUNT     3           consecutive good periods required for lock (>=1)
//
// PORTS
//  i_clk       in   1   system clock
//  i_reset_n   in   1   synchronous reset, active low
//  i_pps       in   1   asynchronous PPS input, rising edge marks the second
//  o_period    out  32  clocks between the last two accepted edges
//  o_err       out  32  signed, o_period - CLOCK_RATE_HZ
//  o_valid     out  1   1-cycle strobe: o_period/o_err updated this cycle
//  o_locked    out  1   LOCK_COUNT consecutive good periods seen
//  o_timeout   out  1   1-cycle strobe: expected edge missing
//  o_led       out  1   toggles on every o_valid
//
// BEHAVIOUR
//  - Sync: s1<=i_pps, s2<=s1, last<=s2; all three reset to 1, so a line held
//    high through reset produces no edge. edge = s2 & !last.
//  - Latency: i_pps first sampled high on clock k -> edge true in cycle after
//    k+1 -> o_valid/o_timeout/o_locked/o_period registered on clock k+2.
//  - Counter r_count (32b): 0 on edge, else +1, saturating at all-ones.
//    Measured period = r_count + 1 (edge-to-edge clock count).
//  - States: IDLE (after reset), TRACK, LOST.
//    IDLE:  edge -> TRACK, r_count<=0; no o_valid, no timeout ever.
//    TRACK: edge -> o_period<=r_count+1, o_err<=period-CLOCK_RATE_HZ,
//           o_valid=1, o_led toggles; stay TRACK.
//           no edge and r_count==CLOCK_RATE_HZ+TOLERANCE -> o_timeout=1,
//           o_locked<=0, good count<=0, -> LOST.
//           edge and timeout threshold in same cycle: edge wins (o_valid,
//           period RATE+TOL+1 is out of tolerance), no o_timeout.
//    LOST:  edge -> TRACK, r_count<=0, no o_valid (previous phase unknown).
//  - Good period: |o_err| <= TOLERANCE (both bounds inclusive).
//  - Lock: r_good 0..LOCK_COUNT saturating; good o_valid -> +1; bad o_valid or
//    timeout -> 0. o_locked = (r_good==LOCK_COUNT), updated on the same clock
//    as the o_valid/o_timeout that changes it.
//  - Reset (any time, incl. mid-period): state IDLE, r_count 0, r_good 0,
//    o_period 0, o_err 0, o_valid 0, o_locked 0, o_timeout 0, o_led 0.
//  - CLOCK_RATE_HZ+TOLERANCE must fit in 32 bits; o_err is 32b two's compl.
//
// TESTING  (CLOCK_RATE_HZ=1000, TOLERANCE=10, LOCK_COUNT=3)
//  1. Reset with i_pps high, hold high 50 clk -> no o_valid, all outputs 0.
//  2. Edges every 1000 clk x4 -> 1st edge no o_valid; next 3 give
//     o_period=1000, o_err=0; o_locked rises with the 3rd o_valid; o_led
//     toggles 3 times.
//  3. Locked, next period 1011 -> o_valid, o_err=+11, o_locked falls same clk.
//  4. Periods 990 then 1010 -> both good; period 989 -> o_err=-11, r_good=0.
//  5. Locked, pulses stop -> o_timeout single pulse 1011 clk after last
//     edge, o_locked=0; next edge no o_valid; edge 1000 later -> o_valid 1000.
//  6. i_reset_n low 1 clk mid-period while locked -> all outputs 0 next clk;
//     next edge only arms (no o_valid); following edge reports normally.

Source files
------------

// File: rtl/pps_rx.sv
// ---------------------------------------------------------------------------
// pps_rx -- receiver / monitor for an external one-pulse-per-second input.
//
// The asynchronous PPS line is synchronised to i_clk. The block counts clocks
// between successive rising edges and reports each measured period together
// with its error against the nominal clock rate. Lock is declared after
// LOCK_COUNT consecutive in-tolerance periods. A missing pulse is flagged once
// the count passes CLOCK_RATE_HZ + TOLERANCE.
//
// Ports
//   i_clk      system clock
//   i_reset_n  synchronous reset, active low
//   i_pps      asynchronous PPS input; a rising edge marks the second
//   o_period   clocks between the last two accepted edges
//   o_err      signed o_period - CLOCK_RATE_HZ (32-bit two's complement)
//   o_valid    1-cycle strobe: o_period / o_err updated this cycle
//   o_locked   LOCK_COUNT consecutive good periods seen
//   o_timeout  1-cycle strobe: expected edge missing
//   o_led      heartbeat, toggles on every o_valid
// ---------------------------------------------------------------------------
module pps_rx #(
    parameter int unsigned CLOCK_RATE_HZ = 50_000_000,
    parameter int unsigned TOLERANCE     = 1_000,
    parameter int unsigned LOCK_COUNT    = 3
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_pps,
    output logic [31:0] o_period,
    output logic [31:0] o_err,
    output logic        o_valid,
    output logic        o_locked,
    output logic        o_timeout,
    output logic        o_led
);

    localparam int GW = (LOCK_COUNT < 1) ? 1 : $clog2(LOCK_COUNT + 1);

    localparam logic        [31:0]   RATE   = 32'(CLOCK_RATE_HZ);
    localparam logic        [31:0]   THRESH = 32'(CLOCK_RATE_HZ + TOLERANCE);
    localparam logic signed [31:0]   TOL_HI = $signed(32'(TOLERANCE));
    localparam logic signed [31:0]   TOL_LO = -TOL_HI;
    localparam logic        [GW-1:0] LOCK_G = GW'(LOCK_COUNT);

    typedef enum logic [1:0] {
        ST_IDLE,   // no reference edge yet since reset
        ST_TRACK,  // reference edge known, periods are reported
        ST_LOST    // pulse went missing, waiting to re-arm
    } state_t;

    state_t         r_state;
    logic           r_s1;
    logic           r_s2;
    logic           r_last;
    logic [31:0]    r_count;
    logic [GW-1:0]  r_good;

    logic           w_edge;
    logic [31:0]    w_period;
    logic [31:0]    w_err;
    logic           w_good;
    logic [GW-1:0]  w_good_inc;

    // NOTE: always_comb assigns every output on every path, so no latch
    // can be inferred.
    always_comb begin
        w_edge     = r_s2 & ~r_last;
        w_period   = r_count + 32'd1;
        w_err      = w_period - RATE;
        w_good     = ($signed(w_err) >= TOL_LO) && ($signed(w_err) <= TOL_HI);
        w_good_inc = (r_good == LOCK_G) ? r_good : r_good + GW'(1);
    end

    // NOTE: all state is updated with non-blocking assignments so that every
    // register samples the pre-edge values of the others.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            // Synchroniser resets high so a line held high through reset
            // does not look like a rising edge afterwards.
            r_s1      <= 1'b1;
            r_s2      <= 1'b1;
            r_last    <= 1'b1;
            r_state   <= ST_IDLE;
            r_count   <= '0;
            r_good    <= '0;
            o_period  <= '0;
            o_err     <= '0;
            o_valid   <= 1'b0;
            o_locked  <= 1'b0;
            o_timeout <= 1'b0;
            o_led     <= 1'b0;
        end else begin
            r_s1    <= i_pps;
            r_s2    <= r_s1;
            r_last  <= r_s2;

            if (w_edge) begin
                r_count <= '0;
            end else if (r_count != '1) begin
                r_count <= r_count + 32'd1;
            end

            o_valid   <= 1'b0;
            o_timeout <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_edge) begin
                        r_state <= ST_TRACK;
                    end
                end
                ST_TRACK: begin
                    // An edge arriving on the timeout cycle takes priority;
                    // its period is RATE+TOL+1 and is simply reported as bad.
                    if (w_edge) begin
                        o_period <= w_period;
                        o_err    <= w_err;
                        o_valid  <= 1'b1;
                        o_led    <= ~o_led;
                        if (w_good) begin
                            r_good   <= w_good_inc;
                            o_locked <= (w_good_inc == LOCK_G);
                        end else begin
                            r_good   <= '0;
                            o_locked <= 1'b0;
                        end
                    end else if (r_count == THRESH) begin
                        o_timeout <= 1'b1;
                        o_locked  <= 1'b0;
                        r_good    <= '0;
                        r_state   <= ST_LOST;
                    end
                end
                ST_LOST: begin
                    // Phase of the previous pulse is unknown: re-arm only.
                    if (w_edge) begin
                        r_state <= ST_TRACK;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pps_rx.sv
// ---------------------------------------------------------------------------
// tb_pps_rx -- self-checking bench for pps_rx (RATE=1000, TOL=10, LOCK=3).
//
// A reference model tracks the time of the last accepted edge in absolute
// cycle numbers and derives every output from timestamps; one compare
// process checks all DUT outputs on every falling edge. Directed pulse
// trains pin known literal values, then randomized periods, pulse widths
// and resets follow.
// ---------------------------------------------------------------------------
module tb_pps_rx;

    localparam int RATE = 1000;
    localparam int TOL  = 10;
    localparam int LOCK = 3;
    localparam int MAXC = 65536;

    logic        i_clk = 1'b0;
    logic        i_reset_n = 1'b0;
    logic        i_pps = 1'b1;
    logic [31:0] o_period;
    logic [31:0] o_err;
    logic        o_valid;
    logic        o_locked;
    logic        o_timeout;
    logic        o_led;

    pps_rx #(
        .CLOCK_RATE_HZ (RATE),
        .TOLERANCE     (TOL),
        .LOCK_COUNT    (LOCK)
    ) dut (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_pps     (i_pps),
        .o_period  (o_period),
        .o_err     (o_err),
        .o_valid   (o_valid),
        .o_locked  (o_locked),
        .o_timeout (o_timeout),
        .o_led     (o_led)
    );

    always #5 i_clk = ~i_clk;

    int n_vec  = 0;
    int n_err  = 0;
    int v_cnt  = 0;
    int t_cnt  = 0;
    int cyc    = 0;

    // Sampled history of the inputs, indexed by clock number.
    bit ph [0:MAXC-1];
    bit rh [0:MAXC-1];

    // Model outputs.
    logic [31:0] m_period = '0;
    logic [31:0] m_err    = '0;
    logic        m_valid  = 1'b0;
    logic        m_locked = 1'b0;
    logic        m_timeout = 1'b0;
    logic        m_led    = 1'b0;
    bit          have_ref = 1'b0;
    int          last_ev  = 0;
    int          streak   = 0;

    function automatic bit rst_at(int x);
        return (x < 1) ? 1'b1 : rh[x];
    endfunction

    // Reset forces the synchroniser high, so a reset cycle looks like a high sample.
    function automatic bit pps_at(int x);
        return (x < 1 || rh[x]) ? 1'b1 : ph[x];
    endfunction

    // Reference model: a rising edge sampled on clock k is acted on at clock
    // k+2; periods are differences of those clock numbers.
    always @(posedge i_clk) begin
        bit ev;
        int per;
        int e;
        cyc = cyc + 1;
        if (cyc < MAXC) begin
            ph[cyc] = i_pps;
            rh[cyc] = !i_reset_n;
        end
        m_valid   = 1'b0;
        m_timeout = 1'b0;
        if (rst_at(cyc)) begin
            m_period = '0;
            m_err    = '0;
            m_locked = 1'b0;
            m_led    = 1'b0;
            have_ref = 1'b0;
            streak   = 0;
        end else begin
            ev = !rst_at(cyc - 1) && !rst_at(cyc - 2) &&
                 pps_at(cyc - 2) && !pps_at(cyc - 3);
            if (ev) begin
                if (have_ref) begin
                    per      = cyc - last_ev;
                    e        = per - RATE;
                    m_period = 32'(per);
                    m_err    = 32'(e);
                    m_valid  = 1'b1;
                    m_led    = ~m_led;
                    if (e >= -TOL && e <= TOL) streak = (streak < LOCK) ? streak + 1 : LOCK;
                    else                       streak = 0;
                    m_locked = (streak == LOCK);
                end
                have_ref = 1'b1;
                last_ev  = cyc;
            end else if (have_ref && (cyc - last_ev == RATE + TOL + 1)) begin
                m_timeout = 1'b1;
                m_locked  = 1'b0;
                have_ref  = 1'b0;
                streak    = 0;
            end
        end
    end

    // Compare process: every output against the model, every cycle.
    always @(negedge i_clk) begin
        if (cyc >= 1) begin
            n_vec = n_vec + 1;
            if (o_period !== m_period || o_err !== m_err || o_valid !== m_valid ||
                o_locked !== m_locked || o_timeout !== m_timeout || o_led !== m_led) begin
                n_err = n_err + 1;
                $display("FAIL cycle %0d: got per=%0d err=%0d v=%b lk=%b to=%b led=%b, want per=%0d err=%0d v=%b lk=%b to=%b led=%b",
                         cyc, o_period, $signed(o_err), o_valid, o_locked, o_timeout, o_led,
                         m_period, $signed(m_err), m_valid, m_locked, m_timeout, m_led);
            end
            if (o_valid === 1'b1)   v_cnt = v_cnt + 1;
            if (o_timeout === 1'b1) t_cnt = t_cnt + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0d (0x%08h), want %0d (0x%08h)", name, act, act, exp, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #2;
    endtask

    // Rising edge now, high for h cycles, total interval p cycles; optional
    // one-cycle reset at offset rst_off (negative for none).
    task automatic pulse(input int p, input int h, input int rst_off);
        for (int i = 0; i < p; i++) begin
            i_pps     = (i < h);
            i_reset_n = (i != rst_off);
            step();
            if (i == rst_off) begin
                check("rst_period", o_period, 32'd0);
                check("rst_err",    o_err,    32'd0);
                check("rst_locked", {31'd0, o_locked}, 32'd0);
                check("rst_led",    {31'd0, o_led},    32'd0);
                check("rst_valid",  {31'd0, o_valid},  32'd0);
            end
        end
        i_reset_n = 1'b1;
    endtask

    initial begin
        // 1: reset with PPS held high, then hold it high for 50 clocks.
        i_reset_n = 1'b0;
        i_pps     = 1'b1;
        repeat (3) step();
        i_reset_n = 1'b1;
        repeat (50) step();
        check("idle_valid_cnt", 32'(v_cnt), 32'd0);
        check("idle_period", o_period, 32'd0);
        check("idle_locked", {31'd0, o_locked}, 32'd0);
        check("idle_led",    {31'd0, o_led},    32'd0);
        i_pps = 1'b0;
        repeat (5) step();

        // 2: four edges 1000 apart -> three reports, lock on the third.
        pulse(1000, 5, -1);
        pulse(1000, 5, -1);
        pulse(1000, 5, -1);
        pulse(1011, 5, -1);
        check("lock_valid_cnt", 32'(v_cnt), 32'd3);
        check("lock_period", o_period, 32'd1000);
        check("lock_err",    o_err,    32'd0);
        check("lock_locked", {31'd0, o_locked}, 32'd1);
        check("lock_led",    {31'd0, o_led},    32'd1);

        // 3: period 1011 coincides with the timeout cycle; edge wins, unlock.
        pulse(990, 5, -1);
        check("p1011_err",    o_err, 32'd11);
        check("p1011_locked", {31'd0, o_locked}, 32'd0);
        check("p1011_no_to",  32'(t_cnt), 32'd0);

        // 4: 990 and 1010 are good, 989 is bad.
        pulse(1010, 5, -1);
        check("p990_err", o_err, 32'hFFFF_FFF6);
        pulse(989, 5, -1);
        check("p1010_err", o_err, 32'd10);

        // 5: last edge, then silence -> one timeout, next edge only re-arms.
        pulse(1200, 5, -1);
        check("p989_err",    o_err, 32'hFFFF_FFF5);
        check("to_cnt",      32'(t_cnt), 32'd1);
        check("to_locked",   {31'd0, o_locked}, 32'd0);
        check("to_valid_cnt", 32'(v_cnt), 32'd7);
        pulse(1000, 5, -1);
        check("rearm_valid_cnt", 32'(v_cnt), 32'd7);
        pulse(1000, 5, -1);
        pulse(1000, 5, -1);
        pulse(1000, 5, -1);
        check("relock_period", o_period, 32'd1000);
        check("relock_locked", {31'd0, o_locked}, 32'd1);

        // 6: reset mid-period while locked; next edge arms, following reports.
        pulse(1000, 5, 500);
        pulse(1000, 5, -1);
        check("post_rst_valid_cnt", 32'(v_cnt), 32'd11);
        pulse(1000, 5, -1);
        check("post_rst_period", o_period, 32'd1000);
        check("post_rst_led",    {31'd0, o_led}, 32'd1);

        // Randomized periods, widths and resets against the model.
        for (int n = 0; n < 24; n++) begin
            int p;
            int h;
            int r;
            case ($urandom_range(0, 9))
                0:       p = RATE + TOL + 2 + int'($urandom_range(0, 300));
                1:       p = RATE + TOL + 1;
                2:       p = RATE - TOL;
                3:       p = RATE + TOL;
                4:       p = RATE - TOL - 1;
                default: p = RATE - 2 * TOL + int'($urandom_range(0, 3 * TOL));
            endcase
            h = int'($urandom_range(1, 20));
            r = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, p - 1)) : -1;
            pulse(p, h, r);
        end
        i_pps = 1'b0;
        repeat (1100) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
